// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : Time-multiplexed 4-digit hex 7-segment driver with a one-deep
//           load buffer. Define SEG7_BLANK_EN for leading-zero blanking.
// Rev     : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int              c_pw       = $clog2(CLK_DIV);
  localparam logic [c_pw-1:0] c_pre_last = c_pw'(CLK_DIV - 1);
  localparam logic [6:0]      c_seg_off  = 7'b1111111;
  localparam logic [3:0]      c_an_off   = 4'b1111;

  logic [c_pw-1:0] r_pre;
  logic [1:0]      r_dig;
  logic [15:0]     r_disp;
  logic [15:0]     r_pend;
  logic            r_full;
  logic [6:0]      r_seg;
  logic [3:0]      r_an;

  logic            w_wrap;
  logic            w_frame_end;
  logic            w_accept;
  logic            w_swap;
  logic [c_pw-1:0] w_pre_nxt;
  logic [1:0]      w_dig_nxt;
  logic [15:0]     w_disp_nxt;
  logic [3:0]      w_nib;
  logic            w_blank_lz;
  logic [6:0]      w_seg_nxt;
  logic [3:0]      w_an_nxt;

  function automatic logic [6:0] f_hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_wrap      = (r_pre == c_pre_last);
  assign w_frame_end = w_wrap && (r_dig == 2'd3);
  assign w_accept    = load_valid && !r_full;
  assign w_swap      = w_frame_end && r_full;

  assign w_pre_nxt  = w_wrap ? '0 : r_pre + 1'b1;
  assign w_dig_nxt  = r_dig + {1'b0, w_wrap};
  assign w_disp_nxt = w_swap ? r_pend : r_disp;

  // Outputs are registered from next-state values so they line up with the slot.
  always_comb begin
    case (w_dig_nxt)
      2'd0:    w_nib = w_disp_nxt[3:0];
      2'd1:    w_nib = w_disp_nxt[7:4];
      2'd2:    w_nib = w_disp_nxt[11:8];
      default: w_nib = w_disp_nxt[15:12];
    endcase
  end

`ifdef SEG7_BLANK_EN
  always_comb begin
    case (w_dig_nxt)
      2'd3:    w_blank_lz = (w_disp_nxt[15:12] == 4'h0);
      2'd2:    w_blank_lz = (w_disp_nxt[15:8] == 8'h00);
      2'd1:    w_blank_lz = (w_disp_nxt[15:4] == 12'h000);
      default: w_blank_lz = 1'b0;
    endcase
  end
`else
  assign w_blank_lz = 1'b0;
`endif

  // First cycle of every slot is dark to avoid ghosting between digits.
  always_comb begin
    w_an_nxt  = c_an_off;
    w_seg_nxt = c_seg_off;
    if (w_pre_nxt != '0) begin
      w_an_nxt = ~(4'b0001 << w_dig_nxt);
      if (!w_blank_lz) begin
        w_seg_nxt = f_hex2seg(w_nib);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_dig  <= 2'd0;
      r_disp <= 16'h0000;
      r_pend <= 16'h0000;
      r_full <= 1'b0;
      r_seg  <= c_seg_off;
      r_an   <= c_an_off;
    end else begin
      r_pre  <= w_pre_nxt;
      r_dig  <= w_dig_nxt;
      r_disp <= w_disp_nxt;
      if (w_swap) begin
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_full <= 1'b1;
      end
      if (w_accept) begin
        r_pend <= load_data;
      end
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign load_ready = ~r_full;
  assign seg        = r_seg;
  assign an         = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Self-checking bench for seg7_scan_driver (table, directed, random).
// Rev     : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;
  localparam logic [6:0] Z  = 7'b1000000;
`ifdef SEG7_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;

  // Reference state: time since reset release plus the buffer contents.
  int          m_t;
  bit          m_full;
  logic [15:0] m_pend;
  logic [15:0] m_disp;
  logic [6:0]  enc_tab [16];

  always #5 clk = ~clk;

  seg7_scan_driver #(.CLK_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .seg        (seg),
    .an         (an)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0d got=%h want=%h", name, m_t, act, exp);
    end
  endtask

  function automatic logic [6:0] m_seg_at(input int t, input logic [15:0] disp);
    int         ph;
    int         dg;
    logic [3:0] nib;
    ph  = t % D;
    dg  = (t / D) % 4;
    nib = 4'(disp >> (4 * dg));
    if (ph == 0) return 7'b1111111;
`ifdef SEG7_BLANK_EN
    if (dg > 0 && (disp >> (4 * dg)) == 16'h0000) return 7'b1111111;
`endif
    return enc_tab[nib];
  endfunction

  function automatic logic [3:0] m_an_at(input int t);
    if ((t % D) == 0) return 4'b1111;
    return 4'(~(32'd1 << ((t / D) % 4)));
  endfunction

  // Check the current cycle against the model, drive inputs, advance one clock.
  task automatic cycle(input bit lv, input logic [15:0] ld);
    bit acc;
    chk("seg", {9'd0, seg}, {9'd0, m_seg_at(m_t, m_disp)});
    chk("an", {12'd0, an}, {12'd0, m_an_at(m_t)});
    chk("load_ready", {15'd0, load_ready}, {15'd0, !m_full});
    load_valid = lv;
    load_data  = ld;
    acc = lv && !m_full;
    if ((m_t % FRAME) == FRAME - 1 && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end
    if (acc) begin
      m_pend = ld;
      m_full = 1'b1;
    end
    m_t++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (m_t < target) cycle(1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    #1;
    chk("rst_async_seg", {9'd0, seg}, 16'h007F);
    chk("rst_async_an", {12'd0, an}, 16'h000F);
    chk("rst_async_ready", {15'd0, load_ready}, 16'h0001);
    repeat (2) @(negedge clk);
    chk("rst_hold_an", {12'd0, an}, 16'h000F);
    rst    = 1'b0;
    m_t    = 0;
    m_full = 1'b0;
    m_pend = 16'h0000;
    m_disp = 16'h0000;
  endtask

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t       vecs [7];
  logic [3:0] an_pat [16];
  logic [3:0] a_exp;
  logic [15:0] rd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0d got=timeout want=finish", m_t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    enc_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    vecs[0] = '{16'h12AF, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
    vecs[1] = '{16'h0123, {LZ,         7'b1111001, 7'b0100100, 7'b0110000}};
    vecs[2] = '{16'h4567, {7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000}};
    vecs[3] = '{16'h89AB, {7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011}};
    vecs[4] = '{16'hCDEF, {7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}};
    vecs[5] = '{16'h0000, {LZ,         LZ,         LZ,         Z}};
    vecs[6] = '{16'h00F0, {LZ,         LZ,         7'b0001110, Z}};
    an_pat  = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

    m_t = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Idle frame after reset: fixed anode sequence, zeros shown.
    for (int t = 0; t < FRAME; t++) begin
      chk("idle_an", {12'd0, an}, {12'd0, an_pat[t]});
      chk("idle_seg", {9'd0, seg},
          {9'd0, ((t % D) == 0) ? 7'b1111111 : ((t / D) == 0 ? Z : LZ)});
      cycle(1'b0, 16'h0000);
    end

    // Table: load mid-frame, check handshake timing and the next frame's digits.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      cycle(1'b0, 16'h0000);
      cycle(1'b1, vecs[i].data);
      chk("tbl_ready_drop", {15'd0, load_ready}, 16'h0000);
      load_valid = 1'b0;
      run_to(FRAME - 1);
      chk("tbl_old_disp", {9'd0, seg}, {9'd0, LZ});
      cycle(1'b0, 16'h0000);
      chk("tbl_ready_back", {15'd0, load_ready}, 16'h0001);
      for (int d = 0; d < 4; d++) begin
        run_to(FRAME + d * D + 1);
        a_exp = ~(4'b0001 << d);
        chk("tbl_an", {12'd0, an}, {12'd0, a_exp});
        chk("tbl_seg", {9'd0, seg}, {9'd0, vecs[i].exp[d]});
      end
    end

    // Valid held while full: second value waits for ready, shows a frame later.
    do_reset();
    cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h1111);
    while (m_t < FRAME) cycle(1'b1, 16'h2222);
    chk("hold_ready_back", {15'd0, load_ready}, 16'h0001);
    cycle(1'b1, 16'h2222);
    chk("hold_accepted", {15'd0, load_ready}, 16'h0000);
    chk("hold_first_frame", {9'd0, seg}, 16'h0079);
    run_to(2 * FRAME + 1);
    chk("hold_second_frame", {9'd0, seg}, 16'h0024);

    // Offer on the frame-boundary cycle while full.
    do_reset();
    cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h0003);
    run_to(FRAME - 1);
    chk("bnd_full", {15'd0, load_ready}, 16'h0000);
    cycle(1'b1, 16'h0007);
    chk("bnd_rejected", {15'd0, load_ready}, 16'h0001);
    cycle(1'b1, 16'h0008);
    chk("bnd_next_accept", {15'd0, load_ready}, 16'h0000);
    chk("bnd_cur_frame", {9'd0, seg}, 16'h0030);
    run_to(2 * FRAME + 1);
    chk("bnd_later_frame", {9'd0, seg}, 16'h0000);

    // Asynchronous reset during digit 2 with pending full.
    do_reset();
    cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h5A5A);
    run_to(2 * D + 2);
    chk("mid_ready", {15'd0, load_ready}, 16'h0000);
    chk("mid_an", {12'd0, an}, 16'h000B);
    @(posedge clk);
    #2;
    do_reset();
    run_to(1);
    chk("rst_restart_an", {12'd0, an}, 16'h000E);
    chk("rst_restart_seg", {9'd0, seg}, {9'd0, Z});
    run_to(FRAME + 1);
    chk("rst_pend_discard", {9'd0, seg}, {9'd0, Z});

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        rd = 16'($urandom);
        case ($urandom_range(0, 4))
          0: rd = rd & 16'h0FFF;
          1: rd = rd & 16'h00FF;
          2: rd = rd & 16'h000F;
          3: rd = 16'h0000;
          default: ;
        endcase
        cycle($urandom_range(0, 2) == 0, rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
